// File: rtl/ddr3_axi_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_axi_pkg
// Shared AXI encodings for the DDR3 read-path front end.
//   - BURST_TYPE_* : AXI ARBURST encodings
//   - RESP_*       : AXI RRESP encodings. The numeric order is also the
//                    severity order: OKAY < EXOKAY < SLVERR < DECERR.
//   - split_state_e: state type for the read splitter FSM
//   - resp_worst() : the more severe of two responses
// ---------------------------------------------------------------------------
package ddr3_axi_pkg;

  localparam logic [1:0] BURST_TYPE_FIXED = 2'b00;
  localparam logic [1:0] BURST_TYPE_INCR  = 2'b01;
  localparam logic [1:0] BURST_TYPE_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_flag_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_flag_fifo
// Small show-ahead synchronous FIFO. The head entry is visible on dout_o
// whenever empty_o is low.
// Ports:
//   clock, reset   : clock and synchronous active-high reset (empties FIFO)
//   push_i, din_i  : write request and data
//   pop_i          : read request (advances the head)
//   dout_o         : head entry
//   full_o, empty_o: status
// A push while full is accepted only if a pop happens in the same cycle.
// DEPTH must be a power of two, 2 or more.
// ---------------------------------------------------------------------------
module ddr3_flag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // The pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/ddr3_axi_rd_splitter.sv
// ---------------------------------------------------------------------------
// ddr3_axi_rd_splitter
// AXI4 read pre-stage in front of the DDR3 controller. It splits each INCR
// read burst into sub-bursts. Each sub-burst has at most MAX_BEATS beats and
// stays within one BOUNDARY_BYTES-aligned page. The returned R beats are
// merged back into one burst with a single RLAST. FIXED and WRAP bursts pass
// through as one request.
//
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   s_ar*             : upstream AR channel (valid/ready/addr/id/len/burst)
//   s_r*              : merged upstream R channel (valid/ready/last/resp/id/data)
//   m_ar*             : AR channel to the controller (one request per sub-burst)
//   m_r*              : R channel from the controller (RLAST per sub-burst)
//
// Optional build macro RD_SPLIT_RESP_ACCUM_EN: when it is defined, s_rresp_o
// reports the worst response seen so far in the parent burst. When it is
// undefined, s_rresp_o follows m_rresp_i beat by beat.
// ---------------------------------------------------------------------------
module ddr3_axi_rd_splitter
  import ddr3_axi_pkg::*;
#(
  parameter int ADDRS           = 29,
  parameter int ID_WIDTH        = 4,
  parameter int DATA_BITS       = 32,
  parameter int MAX_BEATS       = 16,
  parameter int BOUNDARY_BYTES  = 2048,
  parameter int LAST_FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  // upstream AR
  input  logic                 s_arvalid_i,
  output logic                 s_arready_o,
  input  logic [ADDRS-1:0]     s_araddr_i,
  input  logic [ID_WIDTH-1:0]  s_arid_i,
  input  logic [7:0]           s_arlen_i,
  input  logic [1:0]           s_arburst_i,
  // upstream R
  output logic                 s_rvalid_o,
  input  logic                 s_rready_i,
  output logic                 s_rlast_o,
  output logic [1:0]           s_rresp_o,
  output logic [ID_WIDTH-1:0]  s_rid_o,
  output logic [DATA_BITS-1:0] s_rdata_o,
  // controller AR
  output logic                 m_arvalid_o,
  input  logic                 m_arready_i,
  output logic [ADDRS-1:0]     m_araddr_o,
  output logic [ID_WIDTH-1:0]  m_arid_o,
  output logic [7:0]           m_arlen_o,
  output logic [1:0]           m_arburst_o,
  // controller R
  input  logic                 m_rvalid_i,
  output logic                 m_rready_o,
  input  logic                 m_rlast_i,
  input  logic [1:0]           m_rresp_i,
  input  logic [ID_WIDTH-1:0]  m_rid_i,
  input  logic [DATA_BITS-1:0] m_rdata_i
);

  localparam int BEAT_BYTES = DATA_BITS / 8;
  localparam int BEAT_LG    = $clog2(BEAT_BYTES);
  localparam int BND_LG     = $clog2(BOUNDARY_BYTES);
  localparam int BND_BEATS  = BOUNDARY_BYTES / BEAT_BYTES;
  localparam int IDX_W      = BND_LG - BEAT_LG;

  // ---------------- AR side state ----------------
  split_state_e           state_q, state_d;
  logic                   s_arready_q, s_arready_d;
  logic [ADDRS-1:0]       addr_q, addr_d;
  logic [8:0]             rem_q, rem_d;      // beats still to request (1..256)
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [1:0]             burst_q, burst_d;

  logic [IDX_W-1:0]       beat_idx;
  logic [15:0]            bnd_w;
  logic [8:0]             cap_beats;
  logic [8:0]             sub_beats;
  logic [8:0]             sub_beats_m1;
  logic                   is_last_sub;
  logic                   ar_fire;

  // FIFO of last-flags, one entry per issued sub-burst
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_head;
  logic                   fifo_pop;

  // bnd uses the truncated beat index, so a beat-misaligned start address
  // is treated as if it pointed to the start of its beat.
  assign beat_idx = addr_q[BND_LG-1:BEAT_LG];
  assign bnd_w    = 16'(BND_BEATS) - 16'(beat_idx);

  always_comb begin
    cap_beats = 9'(MAX_BEATS);
    if (bnd_w < 16'(MAX_BEATS)) cap_beats = bnd_w[8:0];
    if (burst_q == BURST_TYPE_INCR) begin
      sub_beats = (rem_q < cap_beats) ? rem_q : cap_beats;
    end else begin
      // FIXED/WRAP go out whole; splitting would change their address pattern.
      sub_beats = rem_q;
    end
  end

  assign sub_beats_m1 = sub_beats - 9'd1;
  assign is_last_sub  = (sub_beats == rem_q);

  // The AR request is derived from registers. It can change only after a
  // handshake, so it stays stable while the controller stalls. Full is
  // reached only through a push, which means valid never drops before a
  // request has been accepted.
  assign m_arvalid_o = (state_q == ST_SPLIT) & ~fifo_full;
  assign m_araddr_o  = addr_q;
  assign m_arid_o    = id_q;
  assign m_arburst_o = burst_q;
  assign m_arlen_o   = (state_q == ST_SPLIT) ? sub_beats_m1[7:0] : 8'd0;
  assign s_arready_o = s_arready_q;
  assign ar_fire     = m_arvalid_o & m_arready_i;

  always_comb begin
    state_d     = state_q;
    s_arready_d = s_arready_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    id_d        = id_q;
    burst_d     = burst_q;
    case (state_q)
      ST_IDLE: begin
        s_arready_d = 1'b1;
        if (s_arvalid_i && s_arready_q) begin
          addr_d      = s_araddr_i;
          id_d        = s_arid_i;
          burst_d     = s_arburst_i;
          rem_d       = {1'b0, s_arlen_i} + 9'd1;
          state_d     = ST_SPLIT;
          s_arready_d = 1'b0;
        end
      end
      ST_SPLIT: begin
        s_arready_d = 1'b0;
        if (ar_fire) begin
          // Address arithmetic wraps naturally at 2^ADDRS.
          addr_d = addr_q + (ADDRS'(sub_beats) << BEAT_LG);
          rem_d  = rem_q - sub_beats;
          if (is_last_sub) begin
            state_d     = ST_IDLE;
            s_arready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        s_arready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s_arready_q <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      id_q        <= '0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      s_arready_q <= s_arready_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      id_q        <= id_d;
      burst_q     <= burst_d;
    end
  end

  // ---------------- last-flag FIFO ----------------
  ddr3_flag_fifo #(
    .WIDTH (1),
    .DEPTH (LAST_FIFO_DEPTH)
  ) u_last_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (ar_fire),
    .din_i   (is_last_sub),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- R path (combinational) ----------------
  assign s_rvalid_o = m_rvalid_i;
  assign m_rready_o = s_rready_i;
  assign s_rdata_o  = m_rdata_i;
  assign s_rid_o    = m_rid_i;
  // An RLAST that arrives while the FIFO is empty is dropped and never pops.
  assign s_rlast_o  = m_rlast_i & ~fifo_empty & fifo_head;
  assign fifo_pop   = m_rvalid_i & m_rready_o & m_rlast_i & ~fifo_empty;

`ifdef RD_SPLIT_RESP_ACCUM_EN
  logic [1:0] accum_q, accum_d;
  logic [1:0] resp_now;

  assign resp_now  = resp_worst(accum_q, m_rresp_i);
  assign s_rresp_o = resp_now;

  always_comb begin
    accum_d = accum_q;
    if (m_rvalid_i && m_rready_o) begin
      accum_d = s_rlast_o ? RESP_OKAY : resp_now;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) accum_q <= RESP_OKAY;
    else       accum_q <= accum_d;
  end
`else
  assign s_rresp_o = m_rresp_i;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && m_rvalid_i && m_rready_o && m_rlast_i) begin
      assert (!fifo_empty)
        else $error("ddr3_axi_rd_splitter: sub-burst RLAST with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_axi_rd_splitter.sv
module tb_ddr3_axi_rd_splitter;
  import ddr3_axi_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_arvalid_i = 1'b0;
  logic        s_arready_o;
  logic [28:0] s_araddr_i = '0;
  logic [3:0]  s_arid_i = '0;
  logic [7:0]  s_arlen_i = '0;
  logic [1:0]  s_arburst_i = '0;
  logic        s_rvalid_o;
  logic        s_rready_i = 1'b0;
  logic        s_rlast_o;
  logic [1:0]  s_rresp_o;
  logic [3:0]  s_rid_o;
  logic [31:0] s_rdata_o;
  logic        m_arvalid_o;
  logic        m_arready_i = 1'b0;
  logic [28:0] m_araddr_o;
  logic [3:0]  m_arid_o;
  logic [7:0]  m_arlen_o;
  logic [1:0]  m_arburst_o;
  logic        m_rvalid_i = 1'b0;
  logic        m_rready_o;
  logic        m_rlast_i = 1'b0;
  logic [1:0]  m_rresp_i = '0;
  logic [3:0]  m_rid_i = '0;
  logic [31:0] m_rdata_i = '0;

  int total = 0;
  int bad   = 0;
  logic [3:0] cur_id = '0;
  bit sticky = 1'b0;

  always #5 clock = ~clock;

  ddr3_axi_rd_splitter dut (
    .clock       (clock),
    .reset       (reset),
    .s_arvalid_i (s_arvalid_i),
    .s_arready_o (s_arready_o),
    .s_araddr_i  (s_araddr_i),
    .s_arid_i    (s_arid_i),
    .s_arlen_i   (s_arlen_i),
    .s_arburst_i (s_arburst_i),
    .s_rvalid_o  (s_rvalid_o),
    .s_rready_i  (s_rready_i),
    .s_rlast_o   (s_rlast_o),
    .s_rresp_o   (s_rresp_o),
    .s_rid_o     (s_rid_o),
    .s_rdata_o   (s_rdata_o),
    .m_arvalid_o (m_arvalid_o),
    .m_arready_i (m_arready_i),
    .m_araddr_o  (m_araddr_o),
    .m_arid_o    (m_arid_o),
    .m_arlen_o   (m_arlen_o),
    .m_arburst_o (m_arburst_o),
    .m_rvalid_i  (m_rvalid_i),
    .m_rready_o  (m_rready_o),
    .m_rlast_i   (m_rlast_i),
    .m_rresp_i   (m_rresp_i),
    .m_rid_i     (m_rid_i),
    .m_rdata_i   (m_rdata_i)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic send_ar(input logic [28:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id);
    s_arvalid_i = 1'b1;
    s_araddr_i  = addr;
    s_arlen_i   = len;
    s_arburst_i = burst;
    s_arid_i    = id;
    cur_id      = id;
    #1;
    for (int k = 0; k < 20 && s_arready_o !== 1'b1; k++) tick();
    chk("ar_accept", 32'(s_arready_o), 32'd1);
    tick();
    s_arvalid_i = 1'b0;
    chk("ar_ready_drop", 32'(s_arready_o), 32'd0);
    $display("txn AR-in  addr=0x%07h len=%0d burst=%0d id=%0d", addr, len, burst, id);
  endtask

  task automatic expect_ar(input logic [28:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall);
    m_arready_i = 1'b0;
    for (int k = 0; k < 20 && m_arvalid_o !== 1'b1; k++) tick();
    chk("m_arvalid", 32'(m_arvalid_o), 32'd1);
    for (int s = 0; s < stall; s++) begin
      chk("stall_addr", 32'(m_araddr_o), 32'(addr));
      chk("stall_len", 32'(m_arlen_o), 32'(len));
      tick();
      chk("stall_valid", 32'(m_arvalid_o), 32'd1);
    end
    m_arready_i = 1'b1;
    #1;
    chk("m_araddr", 32'(m_araddr_o), 32'(addr));
    chk("m_arlen", 32'(m_arlen_o), 32'(len));
    chk("m_arburst", 32'(m_arburst_o), 32'(burst));
    chk("m_arid", 32'(m_arid_o), 32'(cur_id));
    tick();
    m_arready_i = 1'b0;
    $display("txn AR-out addr=0x%07h len=%0d burst=%0d", m_araddr_o, m_arlen_o, m_arburst_o);
  endtask

  // One controller sub-burst of nb beats; err is the beat index carrying SLVERR (-1 = none).
  task automatic r_sub(input int nb, input bit final_sub, input int err);
    logic [1:0] exp_resp;
    logic [31:0] d;
    for (int i = 0; i < nb; i++) begin
      d = $urandom;
      m_rvalid_i = 1'b1;
      s_rready_i = 1'b1;
      m_rlast_i  = (i == nb - 1);
      m_rdata_i  = d;
      m_rid_i    = cur_id;
      m_rresp_i  = (i == err) ? RESP_SLVERR : RESP_OKAY;
      #1;
`ifdef RD_SPLIT_RESP_ACCUM_EN
      if (i == err) sticky = 1'b1;
      exp_resp = sticky ? RESP_SLVERR : RESP_OKAY;
`else
      exp_resp = (i == err) ? RESP_SLVERR : RESP_OKAY;
`endif
      chk("s_rlast", 32'(s_rlast_o), 32'(final_sub && (i == nb - 1)));
      chk("s_rvalid", 32'(s_rvalid_o), 32'd1);
      chk("s_rdata", s_rdata_o, d);
      chk("s_rid", 32'(s_rid_o), 32'(cur_id));
      chk("s_rresp", 32'(s_rresp_o), 32'(exp_resp));
      tick();
      if (final_sub && (i == nb - 1)) sticky = 1'b0;
    end
    m_rvalid_i = 1'b0;
    m_rlast_i  = 1'b0;
    m_rresp_i  = RESP_OKAY;
    $display("txn R-sub  beats=%0d final=%0d id=%0d", nb, final_sub, cur_id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_arready", 32'(s_arready_o), 32'd0);
    chk("rst_arvalid", 32'(m_arvalid_o), 32'd0);
    chk("rst_araddr", 32'(m_araddr_o), 32'd0);
    chk("rst_arlen", 32'(m_arlen_o), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_rel_arready", 32'(s_arready_o), 32'd0);
    tick();
    chk("post_rst_arready", 32'(s_arready_o), 32'd1);

    // ---------------- 64-beat INCR -> 4 x 16 ----------------
    send_ar(29'h0000, 8'd63, BURST_TYPE_INCR, 4'd3);
    expect_ar(29'h000, 8'd15, BURST_TYPE_INCR, 0);
    expect_ar(29'h040, 8'd15, BURST_TYPE_INCR, 0);
    expect_ar(29'h080, 8'd15, BURST_TYPE_INCR, 0);
    expect_ar(29'h0C0, 8'd15, BURST_TYPE_INCR, 0);
    chk("t1_done_valid", 32'(m_arvalid_o), 32'd0);
    chk("t1_done_ready", 32'(s_arready_o), 32'd1);
    for (int j = 0; j < 4; j++) r_sub(16, j == 3, -1);

    // ---------------- page-boundary split, with AR stall ----------------
    send_ar(29'h07F0, 8'd7, BURST_TYPE_INCR, 4'd5);
    expect_ar(29'h07F0, 8'd3, BURST_TYPE_INCR, 3);
    expect_ar(29'h0800, 8'd3, BURST_TYPE_INCR, 0);
    r_sub(4, 1'b0, -1);
    r_sub(4, 1'b1, -1);

    // ---------------- WRAP passes through whole ----------------
    send_ar(29'h0008, 8'd3, BURST_TYPE_WRAP, 4'd9);
    expect_ar(29'h0008, 8'd3, BURST_TYPE_WRAP, 0);
    m_rvalid_i = 1'b1;
    s_rready_i = 1'b0;
    #1;
    chk("rready_pass", 32'(m_rready_o), 32'd0);
    tick();
    r_sub(4, 1'b1, -1);

    // ---------------- address wrap at 2^29 ----------------
    send_ar(29'h1FFFFFF8, 8'd3, BURST_TYPE_INCR, 4'd7);
    expect_ar(29'h1FFFFFF8, 8'd1, BURST_TYPE_INCR, 0);
    expect_ar(29'h0000000, 8'd1, BURST_TYPE_INCR, 0);
    r_sub(2, 1'b0, -1);
    r_sub(2, 1'b1, -1);

    // ---------------- FIFO full with 256-beat burst ----------------
    send_ar(29'h1000, 8'd255, BURST_TYPE_INCR, 4'd1);
    for (int k = 0; k < 8; k++) expect_ar(29'(32'h1000 + 64 * k), 8'd15, BURST_TYPE_INCR, 0);
    for (int c = 0; c < 10; c++) begin
      chk("full_valid", 32'(m_arvalid_o), 32'd0);
      chk("full_addr", 32'(m_araddr_o), 32'h1200);
      chk("full_len", 32'(m_arlen_o), 32'd15);
      tick();
    end
    for (int k = 8; k < 16; k++) begin
      r_sub(16, 1'b0, -1);
      chk("resume_valid", 32'(m_arvalid_o), 32'd1);
      expect_ar(29'(32'h1000 + 64 * k), 8'd15, BURST_TYPE_INCR, 0);
    end
    chk("t4_done_ready", 32'(s_arready_o), 32'd1);
    for (int j = 0; j < 8; j++) r_sub(16, j == 7, -1);

    // ---------------- reset during SPLIT ----------------
    send_ar(29'h2000, 8'd31, BURST_TYPE_INCR, 4'd2);
    expect_ar(29'h2000, 8'd15, BURST_TYPE_INCR, 0);
    chk("mid_split_valid", 32'(m_arvalid_o), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(m_arvalid_o), 32'd0);
    chk("mid_rst_arready", 32'(s_arready_o), 32'd0);
    chk("mid_rst_addr", 32'(m_araddr_o), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rel_arready", 32'(s_arready_o), 32'd0);
    tick();
    chk("mid_after_arready", 32'(s_arready_o), 32'd1);
    chk("mid_after_valid", 32'(m_arvalid_o), 32'd0);
    // A stale flag left in the FIFO would suppress this RLAST.
    send_ar(29'h0100, 8'd1, BURST_TYPE_INCR, 4'd6);
    expect_ar(29'h0100, 8'd1, BURST_TYPE_INCR, 0);
    r_sub(2, 1'b1, -1);

    // ---------------- response handling ----------------
    send_ar(29'h3000, 8'd31, BURST_TYPE_INCR, 4'd4);
    expect_ar(29'h3000, 8'd15, BURST_TYPE_INCR, 0);
    expect_ar(29'h3040, 8'd15, BURST_TYPE_INCR, 0);
    r_sub(16, 1'b0, 4);
    r_sub(16, 1'b1, -1);
    send_ar(29'h3100, 8'd3, BURST_TYPE_INCR, 4'd4);
    expect_ar(29'h3100, 8'd3, BURST_TYPE_INCR, 0);
    r_sub(4, 1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr3_axi_rd_splitter.md
Name: ddr3_axi_rd_splitter

Overview:
- AXI4 read-channel pre-stage that sits directly upstream of the DDR3 controller's AR/R ports.
- Splits each incoming INCR read burst into sub-bursts. No sub-burst exceeds MAX_BEATS, and none crosses a BOUNDARY_BYTES-aligned DDR3 page/row boundary.
- Merges the returned R beats back into one burst with a single RLAST.
- Keeps the controller's per-request work bounded and page-local.

Parameters:
- ADDRS, 29, byte-address width (DDR_ROW_BITS + DDR_COL_BITS + 4).
- ID_WIDTH, 4, AXI ID width.
- DATA_BITS, 32, R data width; beat size = DATA_BITS/8 bytes.
- MAX_BEATS, 16, maximum sub-burst length in beats; power of two, 1..256.
- BOUNDARY_BYTES, 2048, sub-bursts never cross a multiple of this; power of two, ≥ MAX_BEATS×beat size.
- LAST_FIFO_DEPTH, 8, outstanding sub-bursts tracked; power of two.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_arvalid_i  in  1  upstream AR valid
- s_arready_o  out  1  upstream AR ready
- s_araddr_i  in  ADDRS  byte address
- s_arid_i  in  ID_WIDTH  transaction ID
- s_arlen_i  in  8  beats-1
- s_arburst_i  in  2  burst type
- s_rvalid_o  out  1  merged R valid
- s_rready_i  in  1  upstream R ready
- s_rlast_o  out  1  last beat of the parent burst
- s_rresp_o  out  2  response
- s_rid_o  out  ID_WIDTH  response ID
- s_rdata_o  out  DATA_BITS  read data
- m_arvalid_o  out  1  AR valid to controller
- m_arready_i  in  1  AR ready from controller
- m_araddr_o  out  ADDRS  sub-burst address
- m_arid_o  out  ID_WIDTH  ID (copied from parent)
- m_arlen_o  out  8  sub-burst beats-1
- m_arburst_o  out  2  burst type (copied from parent)
- m_rvalid_i  in  1  R valid from controller
- m_rready_o  out  1  R ready to controller
- m_rlast_i  in  1  last beat of a sub-burst
- m_rresp_i  in  2  response
- m_rid_i  in  ID_WIDTH  response ID
- m_rdata_i  in  DATA_BITS  read data

Behaviour:
- Reset values:
  - All registered outputs are cleared: s_arready_o=0, m_arvalid_o=0, m_araddr_o/m_arlen_o/m_arid_o/m_arburst_o=0.
  - Last-flag FIFO is emptied; FSM enters IDLE.
  - Any in-flight parent burst is abandoned.
  - R outputs are combinational from m_r*, so s_rvalid_o follows m_rvalid_i, gated as below.
- FSM states: IDLE, SPLIT.
  - IDLE:
    - s_arready_o=1.
    - On s_arvalid_i & s_arready_o: register addr, id, burst and rem = arlen+1 (9 bits); go to SPLIT.
    - s_arready_o is registered and drops the cycle after acceptance.
  - SPLIT:
    - m_arvalid_o=1 while the last-flag FIFO is not full.
    - For INCR, n = min(rem, MAX_BEATS, bnd), where bnd = BOUNDARY_BYTES/beat − addr[log2(BOUNDARY_BYTES)-1 : log2(beat)].
    - m_arlen_o = n−1, m_araddr_o = addr (a beat-misaligned address is forwarded unaltered; bnd uses the truncated beat index).
    - On m_arvalid_o & m_arready_i:
      - addr += n×beat size;
      - rem −= n;
      - push flag (rem==n) into the FIFO;
      - if rem==n, return to IDLE (s_arready_o=1 next cycle).
  - FIXED/WRAP bursts: forwarded as one unmodified request with flag=1. WRAP/FIXED are never split.
  - m_ar* outputs stay stable while m_arvalid_o & ~m_arready_i (AXI rule).
- Latency:
  - 1 cycle from s_ar handshake to first m_arvalid_o.
  - Back-to-back sub-bursts issue every cycle while m_arready_i=1.
  - One idle cycle between parent bursts.
- R path (zero latency, combinational):
  - s_rvalid_o = m_rvalid_i; m_rready_o = s_rready_i.
  - s_rdata_o/s_rid_o/s_rresp_o pass through.
  - s_rlast_o = m_rlast_i & fifo_head.
  - FIFO pops on m_rvalid_i & m_rready_o & m_rlast_i.
- Boundary conditions:
  - FIFO full: m_arvalid_o held low, no push.
  - FIFO pop and push in the same cycle while full: the push is allowed.
  - m_rlast_i beat while FIFO is empty is a protocol error: flagged by a simulation assertion; s_rlast_o=0 and no pop.
  - addr wraps modulo 2^ADDRS.
  - arlen=255 with MAX_BEATS=16 gives 16 sub-bursts.
  - Responses are in order; the controller does not reorder.

Optional Feature:
- Macro RD_SPLIT_RESP_ACCUM_EN.
- Defined:
  - A sticky 2-bit worst-case response (max of rresp) accumulates across all beats of the parent burst.
  - s_rresp_o = max(accum, m_rresp_i).
  - accum is cleared after the parent's final beat handshake and on reset.
- Undefined: s_rresp_o = m_rresp_i per beat.

Decomposition:
- Shared package ddr3_axi_pkg holds the burst-type constants (BURST_TYPE_FIXED/INCR/WRAP) and the RESP_OKAY/EXOKAY/SLVERR/DECERR encodings.
- One sub-module: a generic sync FIFO for the last-flags, ddr3_flag_fifo (width 1, depth LAST_FIFO_DEPTH, full/empty outputs).

Test Plan:
- INCR, addr=0x0000, arlen=63 (64 beats), MAX_BEATS=16 -> four m_ar requests at 0x000/0x040/0x080/0x0C0, each len 15; s_rlast_o only on beat 64.
- INCR, addr=0x07F0 (beat index 508), arlen=7 -> m_ar {0x07F0, len 3} then {0x0800, len 3}; no page crossing.
- WRAP, arlen=3 at 0x0008 -> single m_ar unchanged, len 3, burst WRAP; s_rlast_o on beat 4.
- m_arready_i=0 for 10 cycles with 8 sub-bursts outstanding and no R returns -> m_arvalid_o deasserts at FIFO full, resumes after first m_rlast pop; address/len stable throughout.
- Reset asserted mid-SPLIT (rem=32) -> next cycle m_arvalid_o=0, s_arready_o=0, FIFO empty; s_arready_o=1 the cycle after reset deasserts.
- With RD_SPLIT_RESP_ACCUM_EN: SLVERR on beat 5 of a 32-beat burst -> s_rresp_o=SLVERR on beats 5..32, OKAY on next burst.
